gearbox_downsizing_2x: RTL and testbench

AXI-Stream width gearbox that splits each 2n-byte input beat into two n-byte output beats, upper half first. It is the mirror of `gearbox_upsizing_2x` and sits on the transmit side of that path. Chaining upsizing into downsizing must reproduce the original n-byte stream byte-for-byte. A one-word skid buffer keeps `in_tready` registered and sustains one output beat per cycle.

---
 rtl/gearbox_downsizing_2x.sv | 91 +++++++++
 tb/tb_gearbox_downsizing_2x.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gearbox_downsizing_2x.sv
// AXI-Stream 2:1 width gearbox. Each 2n-byte input word is sent as two n-byte beats,
// upper half first. A one-word skid register lets in_tready come straight from a flop.
module gearbox_downsizing_2x #(
    parameter int n = 5
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [2*n*8-1:0]   in_tdata,
    input  logic               in_tvalid,
    output logic               in_tready,
    output logic [n*8-1:0]     out_tdata,
    output logic               out_tvalid,
    input  logic               out_tready
);
    localparam int NB = n * 8;

    logic [2*NB-1:0] main_data_q, main_data_d;
    logic            main_valid_q, main_valid_d;
    logic            phase_q, phase_d;
    logic [2*NB-1:0] skid_data_q, skid_data_d;
    logic            skid_valid_q, skid_valid_d;
    logic            in_tready_q, in_tready_d;

    logic out_accept;
    logic in_accept;
    logic main_free;

    assign out_accept = main_valid_q & out_tready;
    assign in_accept  = in_tvalid & in_tready_q;
    // Main can take a new word this edge if it is empty or its LO half leaves now.
    assign main_free  = !main_valid_q | (out_accept & phase_q);

    always_comb begin
        main_data_d  = main_data_q;
        main_valid_d = main_valid_q;
        phase_d      = phase_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;

        if (out_accept) begin
            if (!phase_q) begin
                phase_d = 1'b1;
            end else begin
                phase_d      = 1'b0;
                main_valid_d = 1'b0;
                if (skid_valid_q) begin
                    main_data_d  = skid_data_q;
                    main_valid_d = 1'b1;
                    skid_valid_d = 1'b0;
                end
            end
        end

        // in_accept implies the skid was empty at this edge, since in_tready mirrors it.
        if (in_accept) begin
            if (main_free && !skid_valid_q) begin
                main_data_d  = in_tdata;
                main_valid_d = 1'b1;
                phase_d      = 1'b0;
            end else begin
                skid_data_d  = in_tdata;
                skid_valid_d = 1'b1;
            end
        end

        in_tready_d = !skid_valid_d;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            main_data_q  <= '0;
            main_valid_q <= 1'b0;
            phase_q      <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
            in_tready_q  <= 1'b0;
        end else begin
            main_data_q  <= main_data_d;
            main_valid_q <= main_valid_d;
            phase_q      <= phase_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
            in_tready_q  <= in_tready_d;
        end
    end

    assign in_tready  = in_tready_q;
    assign out_tvalid = main_valid_q;
    assign out_tdata  = phase_q ? main_data_q[NB-1:0] : main_data_q[2*NB-1:NB];

endmodule

// File: tb/tb_gearbox_downsizing_2x.sv
// Directed and randomised checks of the 2:1 downsizing gearbox with a half-word scoreboard.
module tb_gearbox_downsizing_2x;
    localparam int N  = 5;
    localparam int NB = N * 8;

    logic            aclk;
    logic            aresetn;
    logic [2*NB-1:0] in_tdata;
    logic            in_tvalid;
    logic            in_tready;
    logic [NB-1:0]   out_tdata;
    logic            out_tvalid;
    logic            out_tready;

    int n_checks;
    int n_errors;
    int in_cnt;
    int out_cnt;
    logic [NB-1:0] exp_q[$];

    gearbox_downsizing_2x #(.n(N)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_tdata  (in_tdata),
        .in_tvalid (in_tvalid),
        .in_tready (in_tready),
        .out_tdata (out_tdata),
        .out_tvalid(out_tvalid),
        .out_tready(out_tready)
    );

    // clock / reset
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Scoreboard: handshakes are sampled on the falling edge, ahead of the edge that completes them.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (in_tvalid && in_tready) begin
                exp_q.push_back(in_tdata[2*NB-1:NB]);
                exp_q.push_back(in_tdata[NB-1:0]);
                in_cnt++;
            end
            if (out_tvalid && out_tready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 80'(out_tdata), 80'(0) - 80'(1));
                end else begin
                    check("beat", 80'(out_tdata), 80'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            tick();
            k++;
        end
        check(tag, 80'(exp_q.size()), 80'(0));
    endtask

    task automatic rolling_word(input int idx, output logic [2*NB-1:0] w);
        for (int j = 0; j < 2 * N; j++) begin
            w[2*NB-1-8*j -: 8] = 8'(65 + (idx * 2 * N + j) % 26);
        end
    endtask

    logic [2*NB-1:0] w_a, w_b, w_c, w_d;
    int  base_in, base_out;
    bit  stress_done;

    initial begin
        n_checks = 0; n_errors = 0; in_cnt = 0; out_cnt = 0;
        w_a = "ABCDEFGHIJ";
        w_b = "KLMNOPQRST";
        w_c = "UVWXYZabcd";
        w_d = "0123456789";
        aresetn = 1'b0; in_tdata = '0; in_tvalid = 1'b0; out_tready = 1'b0;

        // reset values
        repeat (2) tick();
        check("rst_out_tvalid", 80'(out_tvalid), 80'(0));
        check("rst_out_tdata", 80'(out_tdata), 80'(0));
        check("rst_in_tready", 80'(in_tready), 80'(0));
        aresetn = 1'b1;
        check("rel_in_tready_before_edge", 80'(in_tready), 80'(0));
        tick();
        check("rel_in_tready", 80'(in_tready), 80'(1));

        // single word
        out_tready = 1'b1;
        in_tdata = w_a; in_tvalid = 1'b1;
        tick();
        in_tvalid = 1'b0;
        check("single_v0", 80'(out_tvalid), 80'(1));
        check("single_hi", 80'(out_tdata), 80'("ABCDE"));
        tick();
        check("single_v1", 80'(out_tvalid), 80'(1));
        check("single_lo", 80'(out_tdata), 80'("FGHIJ"));
        tick();
        check("single_idle", 80'(out_tvalid), 80'(0));

        // back-to-back
        in_tdata = w_a; in_tvalid = 1'b1;
        tick();
        check("b2b_b0", 80'(out_tdata), 80'("ABCDE"));
        check("b2b_rdy0", 80'(in_tready), 80'(1));
        in_tdata = w_b;
        tick();
        in_tvalid = 1'b0;
        check("b2b_b1", 80'(out_tdata), 80'("FGHIJ"));
        check("b2b_rdy1", 80'(in_tready), 80'(0));
        tick();
        check("b2b_b2", 80'(out_tdata), 80'("KLMNO"));
        check("b2b_v2", 80'(out_tvalid), 80'(1));
        check("b2b_rdy2", 80'(in_tready), 80'(1));
        tick();
        check("b2b_b3", 80'(out_tdata), 80'("PQRST"));
        tick();
        check("b2b_idle", 80'(out_tvalid), 80'(0));

        // backpressure: three words offered over 8 stalled cycles
        out_tready = 1'b0;
        base_in = in_cnt;
        in_tdata = w_a; in_tvalid = 1'b1;
        tick();
        in_tdata = w_b;
        tick();
        in_tdata = w_c;
        for (int i = 0; i < 6; i++) begin
            check("bp_hold_data", 80'(out_tdata), 80'(w_a[2*NB-1:NB]));
            check("bp_hold_valid", 80'(out_tvalid), 80'(1));
            check("bp_rdy_low", 80'(in_tready), 80'(0));
            tick();
        end
        check("bp_accepted", 80'(in_cnt - base_in), 80'(2));
        in_tvalid = 1'b0;
        out_tready = 1'b1;
        wait_drain("bp_drain");
        tick();
        check("bp_idle", 80'(out_tvalid), 80'(0));

        // random stress
        base_in = in_cnt; base_out = out_cnt; stress_done = 1'b0;
        fork
            begin
                logic [2*NB-1:0] w;
                bit acc;
                int guard;
                for (int i = 0; i < 100; i++) begin
                    in_tvalid = 1'b0;
                    repeat ($urandom_range(0, 3)) tick();
                    rolling_word(i, w);
                    in_tdata = w; in_tvalid = 1'b1;
                    guard = 0;
                    do begin
                        @(negedge aclk);
                        acc = in_tready;
                        tick();
                        guard++;
                    end while (!acc && guard < 100);
                    if (!acc) check("stress_stall", 80'(0), 80'(1));
                end
                in_tvalid = 1'b0;
                wait_drain("stress_drain");
                stress_done = 1'b1;
            end
            begin
                while (!stress_done) begin
                    out_tready = 1'b1;
                    repeat ($urandom_range(1, 6)) tick();
                    out_tready = 1'b0;
                    repeat ($urandom_range(1, 6)) tick();
                end
            end
        join
        check("stress_in_cnt", 80'(in_cnt - base_in), 80'(100));
        check("stress_out_cnt", 80'(out_cnt - base_out), 80'(200));

        // reset while in LO with skid full
        out_tready = 1'b0;
        in_tdata = w_a; in_tvalid = 1'b1;
        tick();
        in_tdata = w_b;
        tick();
        in_tvalid = 1'b0;
        out_tready = 1'b1;
        tick();
        out_tready = 1'b0;
        check("mid_lo", 80'(out_tdata), 80'("FGHIJ"));
        check("mid_skid_full", 80'(in_tready), 80'(0));
        #2;
        aresetn = 1'b0;
        #1;
        check("mid_rst_valid", 80'(out_tvalid), 80'(0));
        check("mid_rst_ready", 80'(in_tready), 80'(0));
        check("mid_rst_data", 80'(out_tdata), 80'(0));
        exp_q.delete();
        tick();
        aresetn = 1'b1;
        tick();
        check("post_rst_ready", 80'(in_tready), 80'(1));
        check("post_rst_valid", 80'(out_tvalid), 80'(0));
        out_tready = 1'b1;
        in_tdata = w_d; in_tvalid = 1'b1;
        tick();
        in_tvalid = 1'b0;
        check("post_rst_hi", 80'(out_tdata), 80'("01234"));
        tick();
        check("post_rst_lo", 80'(out_tdata), 80'("56789"));
        tick();
        check("post_rst_idle", 80'(out_tvalid), 80'(0));
        check("post_rst_queue", 80'(exp_q.size()), 80'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
